// File: rtl/fir_decim_pkg.sv
// -----------------------------------------------------------------------------
// fir_decim_pkg
// Shared constants for the decimating FIR receive filter:
//   MaxTaps        - largest supported tap count
//   CoeffAddrWidth - width of the shadow-bank write address
//   DefaultCoeffs  - 21-tap RRC (alpha 0.5, 4 samples/symbol, gain ~2^14),
//                    zero-padded to MaxTaps; loaded into both banks on reset
//   acc_width()    - full-precision accumulator width for a configuration
// -----------------------------------------------------------------------------
package fir_decim_pkg;

    localparam int MaxTaps        = 32;
    localparam int CoeffAddrWidth = 5;

    typedef logic signed [13:0] def_coeff_t;

    localparam def_coeff_t DefaultCoeffs [MaxTaps] = '{
        -14'sd61,  14'sd63,   14'sd173,  14'sd63,   -14'sd307, -14'sd642,
        -14'sd434, 14'sd642,  14'sd2371, 14'sd3994, 14'sd4658, 14'sd3994,
        14'sd2371, 14'sd642,  -14'sd434, -14'sd642, -14'sd307, 14'sd63,
        14'sd173,  14'sd63,   -14'sd61,
        14'sd0, 14'sd0, 14'sd0, 14'sd0, 14'sd0, 14'sd0,
        14'sd0, 14'sd0, 14'sd0, 14'sd0, 14'sd0
    };

    // Product width plus enough guard bits to sum every tap without overflow.
    function automatic int acc_width(input int in_width, input int coeff_width,
                                     input int num_taps);
        return in_width + coeff_width + $clog2(num_taps);
    endfunction

endpackage

// File: rtl/fir_decim_if.sv
// -----------------------------------------------------------------------------
// fir_decim_if
// Sample stream and coefficient-load bus of the decimating FIR.
//   in_valid/in        - input samples, one per cycle when in_valid is high
//   out_valid/out      - decimated output, out_valid is a single-cycle pulse
//   coeff_wr_*         - write one tap of the shadow coefficient bank
//   coeff_commit       - copy the shadow bank into the active bank
//   overflow           - sticky output-saturation flag
// Modports: master drives samples/coefficients, slave is the filter.
// -----------------------------------------------------------------------------
interface fir_decim_if #(
    parameter int InWidth    = 12,
    parameter int OutWidth   = 12,
    parameter int CoeffWidth = 14
);
    logic                                       in_valid;
    logic signed [InWidth-1:0]                  in;
    logic                                       out_valid;
    logic signed [OutWidth-1:0]                 out;
    logic                                       coeff_wr_en;
    logic [fir_decim_pkg::CoeffAddrWidth-1:0]   coeff_wr_addr;
    logic signed [CoeffWidth-1:0]               coeff_wr_data;
    logic                                       coeff_commit;
    logic                                       overflow;

    modport master (
        output in_valid, in, coeff_wr_en, coeff_wr_addr, coeff_wr_data, coeff_commit,
        input  out_valid, out, overflow
    );

    modport slave (
        input  in_valid, in, coeff_wr_en, coeff_wr_addr, coeff_wr_data, coeff_commit,
        output out_valid, out, overflow
    );
endinterface

// File: rtl/fir_decim_scale.sv
// -----------------------------------------------------------------------------
// fir_decim_scale
// Combinational output scaling: round half up, arithmetic shift right by
// Shift, then reduce to OutWidth.
//   acc_i - full-precision signed accumulator value
//   out_o - scaled OutWidth-bit result
//   sat_o - result fell outside the OutWidth range and was clamped
// FIR_DECIM_SAT_EN defined: clamp to max/min and flag via sat_o.
// Undefined: keep the low OutWidth bits (wrap), sat_o is 0.
// -----------------------------------------------------------------------------
module fir_decim_scale #(
    parameter int AccWidth = 31,
    parameter int Shift    = 14,
    parameter int OutWidth = 12
) (
    input  logic signed [AccWidth-1:0] acc_i,
    output logic signed [OutWidth-1:0] out_o,
    output logic                       sat_o
);
    // One extra bit so adding the rounding constant can never wrap.
    localparam int ExtWidth = ((AccWidth > OutWidth) ? AccWidth : OutWidth) + 1;
    typedef logic signed [ExtWidth-1:0] ext_t;

    localparam ext_t Half   = (Shift > 0) ? (ext_t'(1) <<< ((Shift > 0) ? Shift - 1 : 0))
                                          : ext_t'(0);
    localparam ext_t MaxOut = ext_t'({(OutWidth-1){1'b1}});
    localparam ext_t MinOut = ~MaxOut;

    ext_t rounded;

    always_comb begin
        rounded = (ext_t'(acc_i) + Half) >>> Shift;
    end

`ifdef FIR_DECIM_SAT_EN
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // the branches, so no path can leave it unassigned and infer a latch.
        out_o = rounded[OutWidth-1:0];
        sat_o = 1'b0;
        if (rounded > MaxOut) begin
            out_o = MaxOut[OutWidth-1:0];
            sat_o = 1'b1;
        end else if (rounded < MinOut) begin
            out_o = MinOut[OutWidth-1:0];
            sat_o = 1'b1;
        end
    end
`else
    // Upper bits are discarded on purpose: two's-complement wrap.
    logic unused_upper;
    assign unused_upper = ^rounded[ExtWidth-1:OutWidth];
    assign out_o        = rounded[OutWidth-1:0];
    assign sat_o        = 1'b0;
`endif

endmodule

// File: rtl/fir_decim.sv
// -----------------------------------------------------------------------------
// fir_decim
// Transposed-form FIR with integrated decimator and double-buffered,
// runtime-loadable coefficients.
//   clk  - clock
//   rst  - synchronous active-high reset; restores the default RRC bank
//   bus  - fir_decim_if.slave: sample in/out, coefficient load, overflow
// Every Decimation-th accepted input produces one output, registered one
// cycle after that input. Coefficient writes go to the shadow bank; a commit
// copies it to the active bank without flushing the accumulators.
// FIR_DECIM_SAT_EN selects saturating outputs with a sticky overflow flag;
// without it outputs wrap and overflow stays 0.
// -----------------------------------------------------------------------------
module fir_decim
    import fir_decim_pkg::*;
#(
    parameter int InWidth    = 12,
    parameter int OutWidth   = 12,
    parameter int CoeffWidth = 14,
    parameter int NumTaps    = 21,
    parameter int Decimation = 4,
    parameter int Shift      = 14
) (
    input  logic          clk,
    input  logic          rst,
    fir_decim_if.slave    bus
);
    localparam int AccWidth   = acc_width(InWidth, CoeffWidth, NumTaps);
    localparam int PhaseWidth = (Decimation > 1) ? $clog2(Decimation) : 1;
    localparam logic [PhaseWidth-1:0] LastPhase = PhaseWidth'(Decimation - 1);

    typedef logic signed [CoeffWidth-1:0] coeff_t;
    typedef logic signed [AccWidth-1:0]   acc_t;

    coeff_t                  active_q [NumTaps];
    coeff_t                  active_d [NumTaps];
    coeff_t                  shadow_q [NumTaps];
    coeff_t                  shadow_d [NumTaps];
    acc_t                    prod     [NumTaps];
    acc_t                    tail;      // acc[1], or 0 for a single tap
    acc_t                    acc0;      // value acc[0] takes on this input
    logic [PhaseWidth-1:0]   phase_q, phase_d;
    logic                    fire;
    logic signed [OutWidth-1:0] scaled, out_q, out_d;
    logic                    sat;
    logic                    out_valid_q, out_valid_d;
    logic                    overflow_q, overflow_d;

    // Full-precision products against the bank that is active this cycle.
    always_comb begin
        for (int i = 0; i < NumTaps; i++) begin
            prod[i] = acc_t'(bus.in) * acc_t'(active_q[i]);
        end
    end

    // Shadow writes and commit. The commit copies shadow_q, so a write on
    // the same edge is not part of the committed bank.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < NumTaps; i++) begin
            if (bus.coeff_wr_en && int'(bus.coeff_wr_addr) == i) begin
                shadow_d[i] = bus.coeff_wr_data;
            end
        end
        if (bus.coeff_commit) begin
            active_d = shadow_q;
        end
    end

    // Accumulator chain acc[1..NumTaps-1], stored as chain_q[0..NumTaps-2].
    // acc[0] is never stored: it feeds the output register directly.
    generate
        if (NumTaps > 1) begin : g_chain
            acc_t chain_q [NumTaps-1];
            acc_t chain_d [NumTaps-1];

            always_comb begin
                chain_d = chain_q;
                if (bus.in_valid) begin
                    for (int j = 0; j < NumTaps - 2; j++) begin
                        chain_d[j] = prod[j+1] + chain_q[j+1];
                    end
                    chain_d[NumTaps-2] = prod[NumTaps-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < NumTaps - 1; j++) begin
                        chain_q[j] <= '0;
                    end
                end else begin
                    chain_q <= chain_d;
                end
            end

            assign tail = chain_q[0];
        end else begin : g_no_chain
            assign tail = '0;
        end
    endgenerate

    assign acc0 = prod[0] + tail;

    fir_decim_scale #(
        .AccWidth (AccWidth),
        .Shift    (Shift),
        .OutWidth (OutWidth)
    ) u_scale (
        .acc_i (acc0),
        .out_o (scaled),
        .sat_o (sat)
    );

    // Phase counting and output capture. sat is constant 0 in wrap builds,
    // so overflow never leaves its reset value there.
    always_comb begin
        fire        = bus.in_valid && (phase_q == LastPhase);
        phase_d     = phase_q;
        out_d       = out_q;
        out_valid_d = fire;
        overflow_d  = overflow_q;
        if (bus.in_valid) begin
            phase_d = (phase_q == LastPhase) ? '0 : phase_q + PhaseWidth'(1);
        end
        if (fire) begin
            out_d      = scaled;
            overflow_d = overflow_q | sat;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= only, so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            phase_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            // NOTE: both coefficient banks are flop arrays that must come out
            // of reset holding the default filter, so they are reset
            // explicitly rather than left uninitialised like a RAM.
            for (int i = 0; i < NumTaps; i++) begin
                active_q[i] <= coeff_t'(DefaultCoeffs[i]);
                shadow_q[i] <= coeff_t'(DefaultCoeffs[i]);
            end
        end else begin
            phase_q     <= phase_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fir_decim
// Two filters (Decimation 4 and Decimation 1) share one input stream. A
// direct-form reference keeps every accepted sample with the coefficient bank
// that was active when it arrived and convolves them with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_fir_decim;
    import fir_decim_pkg::*;

    localparam int InW   = 12;
    localparam int OutW  = 12;
    localparam int CW    = 14;
    localparam int Taps  = 21;
    localparam int Shift = 14;
    localparam int Dec   = 4;
    localparam int Hist  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_decim_if #(.InWidth(InW), .OutWidth(OutW), .CoeffWidth(CW)) bus4 ();
    fir_decim_if #(.InWidth(InW), .OutWidth(OutW), .CoeffWidth(CW)) bus1 ();

    fir_decim #(.InWidth(InW), .OutWidth(OutW), .CoeffWidth(CW), .NumTaps(Taps),
                .Decimation(Dec), .Shift(Shift))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    fir_decim #(.InWidth(InW), .OutWidth(OutW), .CoeffWidth(CW), .NumTaps(Taps),
                .Decimation(1), .Shift(Shift))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ---------------- reference model state ----------------
    int  act [MaxTaps];
    int  shd [MaxTaps];
    int  hx  [Hist];
    int  hc  [Hist][MaxTaps];
    int  wr;
    int  n_acc;
    int  exp_out4, exp_out1;
    bit  exp_v4, exp_v1, exp_ov4, exp_ov1;
    int  cyc;

    int  n_checks = 0;
    int  n_errors = 0;

`ifdef FIR_DECIM_SAT_EN
    localparam int  SatOut = 2047;
    localparam bit  SatOvf = 1'b1;
`else
    localparam int  SatOut = 1011;
    localparam bit  SatOvf = 1'b0;
`endif

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MaxTaps; i++) begin
            act[i] = int'(DefaultCoeffs[i]);
            shd[i] = int'(DefaultCoeffs[i]);
        end
        for (int h = 0; h < Hist; h++) begin
            hx[h] = 0;
            for (int k = 0; k < MaxTaps; k++) hc[h][k] = 0;
        end
        wr = 0; n_acc = 0;
        exp_out4 = 0; exp_out1 = 0;
        exp_v4 = 0; exp_v1 = 0; exp_ov4 = 0; exp_ov1 = 0;
    endtask

    // y[n] = sum_k x[n-k] * c_{bank seen by x[n-k]}[k]
    function automatic longint model_dot();
        longint s = 0;
        int idx;
        for (int k = 0; k < Taps; k++) begin
            idx = (wr - k + Hist) % Hist;
            s += longint'(hx[idx]) * longint'(hc[idx][k]);
        end
        return s;
    endfunction

    function automatic int ref_scale(input longint y, output bit ovf);
        longint r;
        r   = (y + (longint'(1) << (Shift - 1))) >>> Shift;
        ovf = 1'b0;
`ifdef FIR_DECIM_SAT_EN
        if (r > 2047)       begin r = 2047;  ovf = 1'b1; end
        else if (r < -2048) begin r = -2048; ovf = 1'b1; end
`else
        r = r & 64'hFFF;
        if (r >= 2048) r = r - 4096;
`endif
        return int'(r);
    endfunction

    // One clock: drive both DUTs, advance the model, compare #1 after the edge.
    task automatic step(input bit r, input bit v, input int x, input bit we,
                        input int wa, input int wd, input bit cm);
        bit     ovf;
        int     s;
        rst = r;
        bus4.in_valid = v;        bus1.in_valid = v;
        bus4.in = InW'(x);        bus1.in = InW'(x);
        bus4.coeff_wr_en = we;    bus1.coeff_wr_en = we;
        bus4.coeff_wr_addr = 5'(wa); bus1.coeff_wr_addr = 5'(wa);
        bus4.coeff_wr_data = CW'(wd); bus1.coeff_wr_data = CW'(wd);
        bus4.coeff_commit = cm;   bus1.coeff_commit = cm;
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            exp_v4 = 1'b0;
            exp_v1 = 1'b0;
            if (v) begin
                wr = (wr + 1) % Hist;
                hx[wr] = x;
                for (int k = 0; k < MaxTaps; k++) hc[wr][k] = act[k];
                n_acc++;
                s = ref_scale(model_dot(), ovf);
                exp_out1 = s; exp_v1 = 1'b1; exp_ov1 |= ovf;
                if (n_acc % Dec == 0) begin
                    exp_out4 = s; exp_v4 = 1'b1; exp_ov4 |= ovf;
                end
            end
            if (cm) act = shd;
            if (we && wa < Taps) shd[wa] = wd;
        end
        #1;
        check("out_valid_d4", bus4.out_valid, exp_v4);
        check("out_d4",       bus4.out,       exp_out4);
        check("overflow_d4",  bus4.overflow,  exp_ov4);
        check("out_valid_d1", bus1.out_valid, exp_v1);
        check("out_d1",       bus1.out,       exp_out1);
        check("overflow_d1",  bus1.overflow,  exp_ov1);
    endtask

    task automatic feed(input bit v, input int x);
        step(1'b0, v, x, 1'b0, 0, 0, 1'b0);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    int smp [40];
    int ref_q [$];
    int gap_q [$];
    int last_pulse;

    initial begin
        cyc = 0;
        model_reset();

        // Reset state
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        check("rst_out",       bus4.out, 0);
        check("rst_out_valid", bus4.out_valid, 0);
        check("rst_overflow",  bus4.overflow, 0);

        // Impulse response on the Decimation=1 filter
        feed(1'b1, 2047);
        check("imp_tap0", bus1.out, -8);
        for (int k = 1; k < 25; k++) begin
            feed(1'b1, 0);
            if (k == 10) check("imp_tap10", bus1.out, 582);
            if (k == 20) check("imp_tap20", bus1.out, -8);
        end

        // DC: steady 1000, pulses exactly Dec cycles apart
        last_pulse = -1;
        for (int i = 0; i < 48; i++) begin
            feed(1'b1, 1000);
            if (bus4.out_valid) begin
                if (last_pulse >= 0) check("dc_pulse_gap", cyc - last_pulse, Dec);
                last_pulse = cyc;
                if (i >= 24) check("dc_level", bus4.out, 1000);
            end
        end

        // Gap-free vs. gapped valid must give identical output sequences
        for (int i = 0; i < 40; i++) smp[i] = rnd_sample();
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            feed(1'b1, smp[i]);
            if (bus4.out_valid) ref_q.push_back(int'(bus4.out));
        end
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            feed(1'b1, smp[i]);
            if (bus4.out_valid) gap_q.push_back(int'(bus4.out));
            feed(1'b0, rnd_sample());
            if (bus4.out_valid) gap_q.push_back(int'(bus4.out));
        end
        check("gap_count", gap_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < ref_q.size() && i < gap_q.size())
                check("gap_vs_nogap", gap_q[i], ref_q[i]);
        end

        // Random stream with random valid and occasional coefficient traffic
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), rnd_sample(),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 16383)) - 8192, ($urandom_range(0, 23) == 0));
        end

        // Coefficient reload while streaming 1024
        step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        for (int a = 0; a < Taps; a++) step(1'b0, 1'b1, 1024, 1'b1, a, (a == 0) ? 8191 : 0, 1'b0);
        step(1'b0, 1'b1, 1024, 1'b1, 25, 1234, 1'b0);
        check("pre_commit", bus1.out, 1024);
        step(1'b0, 1'b1, 1024, 1'b1, 1, 5, 1'b1);
        check("commit_cycle_old_bank", bus1.out, 1024);
        for (int i = 1; i <= 30; i++) begin
            feed(1'b1, 1024);
            if (i >= 21) check("reload_level", bus1.out, 512);
            if (i >= 21 && bus4.out_valid) check("reload_level_d4", bus4.out, 512);
        end

        // Saturation / wrap: all taps 8191, constant 2047
        for (int a = 0; a < Taps; a++) step(1'b0, 1'b1, 2047, 1'b1, a, 8191, 1'b0);
        step(1'b0, 1'b1, 2047, 1'b0, 0, 0, 1'b1);
        for (int i = 1; i <= 25; i++) begin
            feed(1'b1, 2047);
            if (i >= 22) begin
                check("sat_out", bus1.out, SatOut);
                check("sat_flag", bus1.overflow, SatOvf);
            end
        end
        for (int i = 0; i < 5; i++) feed(1'b1, 0);
        check("sat_flag_sticky", bus1.overflow, SatOvf);

        // Reset in the middle of a DC stream
        for (int i = 0; i < 10; i++) feed(1'b1, 1000);
        step(1'b1, 1'b1, 1000, 1'b0, 0, 0, 1'b0);
        check("midrst_out", bus4.out, 0);
        check("midrst_out_valid", bus4.out_valid, 0);
        check("midrst_overflow", bus1.overflow, 0);
        for (int i = 1; i <= 30; i++) begin
            feed(1'b1, 1000);
            if (i <= 4) check("phase_restart", bus4.out_valid, (i == 4) ? 1 : 0);
            if (i >= 21) check("default_bank_restored", bus1.out, 1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_decim.md
Name: fir_decim

Overview:
Parametrised transposed-form FIR filter with an integrated decimator, a valid handshake, runtime-loadable double-buffered coefficients, and round-half-up output scaling. It is the next generation of the team's fixed 21-tap RRC receive filter and sits between the ADC sample front end and the symbol timing recovery. Default parameters and default coefficients reproduce the current 21-tap RRC (alpha 0.5, 4 samples/symbol, gain ~2^14).

Parameters:
InWidth, 12, signed input sample width
OutWidth, 12, signed output sample width
CoeffWidth, 14, signed coefficient width
NumTaps, 21, tap count, 1..32
Decimation, 4, output one sample per Decimation accepted inputs, >= 1
Shift, 14, right shift applied to accumulator for output scaling, >= 0

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  in is valid this cycle
in  in  InWidth  signed input sample
out_valid  out  1  out is valid this cycle (single-cycle pulse)
out  out  OutWidth  signed filtered, decimated sample
coeff_wr_en  in  1  write coeff_wr_data into shadow bank
coeff_wr_addr  in  5  shadow tap index
coeff_wr_data  in  CoeffWidth  signed coefficient
coeff_commit  in  1  copy shadow bank to active bank
overflow  out  1  sticky saturation flag

Behaviour:
- Reset: accumulators=0, phase=0, out=0, out_valid=0, overflow=0; active and shadow banks load fir_decim_pkg::DefaultCoeffs[0..NumTaps-1].
- AccWidth = InWidth+CoeffWidth+$clog2(NumTaps); all products and sums are signed, full precision, no intermediate truncation.
- Accumulator chain updates only on in_valid: acc[i] <= in*c[i] + acc[i+1] for i < NumTaps-1; acc[NumTaps-1] <= in*c[NumTaps-1]. Without in_valid all state holds.
- Phase counter increments on each accepted input and wraps Decimation-1 -> 0; cycles without in_valid do not advance it.
- When in_valid and phase==Decimation-1: next = in*c[0]+acc[1]; out <= scale(next); out_valid <= 1 the following cycle. Latency is 1 cycle from the triggering input. Otherwise out_valid <= 0 and out holds.
- Decimation==1: every accepted input produces an output.
- scale(x): if Shift>0, add 2^(Shift-1), then arithmetic shift right by Shift (round half up); then reduce to OutWidth per the optional feature.
- coeff_wr_en writes shadow[coeff_wr_addr]; addresses >= NumTaps are ignored.
- coeff_commit: active <= shadow at the clock edge. An input accepted on the same cycle uses the old active bank. A write and a commit on the same cycle commit the pre-write shadow value. The accumulators are not flushed.
- rst mid-stream overrides all other inputs that cycle; any loaded coefficients are lost.

Optional Feature:
FIR_DECIM_SAT_EN. Defined: scaled results outside the OutWidth range clamp to the max/min value, and overflow sets and stays set until rst. Undefined: the low OutWidth bits are kept (two's-complement wrap), and overflow is tied 0.

Decomposition:
- fir_decim_pkg: MaxTaps=32, CoeffAddrWidth=5, DefaultCoeffs (32 x 14-bit; the 21 RRC values -61, 63, 173, 63, -307, -642, -434, 642, 2371, 3994, 4658, 3994, 2371, 642, -434, -642, -307, 63, 173, 63, -61, zero-padded), and a function for AccWidth.
- One sub-module, fir_decim_scale: combinational round, shift and saturate/wrap, parametrised on AccWidth, Shift and OutWidth.

Test Plan:
- Impulse, Decimation=1: in=2047 for one valid cycle, then zeros -> outputs in order -8, 8, 22, …, 582 (tap 10), …, -8; out_valid on each following cycle.
- DC, defaults: in=1000 on every cycle -> once the filter fills, every 4th input yields out=1000 (coefficient sum 16382), with out_valid pulses exactly 4 cycles apart.
- Gapped valid, Decimation=4: in_valid toggles 1/0 -> one out_valid per 4 accepted samples; outputs are identical to the gap-free run.
- Coefficient reload: write tap0=8191 and all others 0, commit while streaming in=1024, Shift=14 -> outputs after commit equal round(1024*8191/16384)=512; inputs accepted on the commit cycle use the old bank.
- Saturation (FIR_DECIM_SAT_EN defined): all taps 8191, in=2047 constant -> out=2047 and overflow=1 until rst. With the macro undefined, out shows the wrapped value and overflow=0.
- Reset mid-stream: assert rst during DC test -> next cycle out=0, out_valid=0, default coefficients restored, phase restarts at 0.
